// File: rtl/fifo_apb_master.sv
// Pops command words from a first-word-fall-through FIFO and runs each one as a
// single APB3 transfer, returning one response per command with a pready timeout.
`timescale 1ns/1ps

module fifo_apb_master #(
    parameter int addr_width     = 8,
    parameter int data_width     = 16,
    parameter int cmd_width      = 1 + addr_width + data_width,
    parameter int timeout_cycles = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [cmd_width-1:0]  fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [addr_width-1:0] paddr,
    output logic [data_width-1:0] pwdata,
    input  logic [data_width-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_data,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Abort fires in the timeout_cycles-th ACCESS cycle, i.e. when the count of
    // earlier stalled cycles reaches timeout_cycles-1 (clamped to the 16-bit counter).
    localparam bit          TIMEOUT_EN = (timeout_cycles != 0);
    localparam logic [15:0] WAIT_LAST  = (timeout_cycles == 0)    ? 16'd0 :
                                         (timeout_cycles > 65536) ? 16'hFFFF :
                                         16'(timeout_cycles - 1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    pop_s;
    logic                    done_s;
    logic                    abort_s;
    logic [15:0]             wait_cnt_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [addr_width-1:0]   paddr_r;
    logic [data_width-1:0]   pwdata_r;
    logic                    rsp_valid_r;
    logic [data_width-1:0]   rsp_data_r;
    logic                    rsp_write_r;
    logic                    rsp_err_r;
    logic                    timeout_r;

    // Next-state selection plus the pop / completion / abort strobes
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_s       = 1'b1;
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over an abort landing in the same cycle
                if (pready) begin
                    done_s      = 1'b1;
                    state_nxt_s = RESP;
                end else if (TIMEOUT_EN && (wait_cnt_r >= WAIT_LAST)) begin
                    abort_s     = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign fifo_rd_en = !rst && pop_s;

    // State register and APB/handshake control outputs, registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            psel_r      <= (state_nxt_s == SETUP) || (state_nxt_s == ACCESS);
            penable_r   <= (state_nxt_s == ACCESS);
            rsp_valid_r <= (state_nxt_s == RESP);
            timeout_r   <= abort_s;
        end
    end

    // Command register: captures the FIFO head on the pop edge and holds it for the transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite_r <= 1'b0;
            paddr_r  <= {addr_width{1'b0}};
            pwdata_r <= {data_width{1'b0}};
        end else if (pop_s) begin
            pwrite_r <= fifo_dout[cmd_width-1];
            paddr_r  <= fifo_dout[addr_width+data_width-1:data_width];
            pwdata_r <= fifo_dout[data_width-1:0];
        end
    end

    // Saturating count of stalled ACCESS cycles, restarted for every command
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 16'd0;
        end else if (pop_s) begin
            wait_cnt_r <= 16'd0;
        end else if ((state_r == ACCESS) && !pready && (wait_cnt_r != 16'hFFFF)) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end
    end

    // Response capture: completion or abort loads it, RESP holds it until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_r  <= {data_width{1'b0}};
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else if (done_s) begin
            rsp_write_r <= pwrite_r;
            rsp_err_r   <= pslverr;
            rsp_data_r  <= (pwrite_r || pslverr) ? {data_width{1'b0}} : prdata;
        end else if (abort_s) begin
            rsp_write_r <= pwrite_r;
            rsp_err_r   <= 1'b1;
            rsp_data_r  <= {data_width{1'b0}};
        end
    end

    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_write = rsp_write_r;
    assign rsp_err   = rsp_err_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_fifo_apb_master.sv
// Directed bench for fifo_apb_master: one instance with a 4-cycle timeout and one
// with the timeout disabled, each fed by a small FWFT FIFO model.
`timescale 1ns/1ps

module tb_fifo_apb_master;

    logic        clk;
    logic        rst;

    logic        fifo_empty;
    logic [24:0] fifo_dout;
    logic        fifo_rd_en;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [15:0] pwdata, prdata, prdata_val;
    logic        pready, pslverr;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err, timeout;
    logic [15:0] rsp_data;
    logic        echo_mode;

    logic        fifo_empty_z;
    logic [24:0] fifo_dout_z;
    logic        fifo_rd_en_z;
    logic        psel_z, penable_z, pwrite_z;
    logic [7:0]  paddr_z;
    logic [15:0] pwdata_z, prdata_z;
    logic        pready_z, pslverr_z;
    logic        rsp_valid_z, rsp_ready_z, rsp_write_z, rsp_err_z, timeout_z;
    logic [15:0] rsp_data_z;

    int total, bad, cyc, pops, push_z, pop_z;
    logic [24:0] mem [0:15];
    logic [3:0]  wp, rp;
    int pop_cyc [0:15];

    fifo_apb_master #(.addr_width(8), .data_width(16), .timeout_cycles(4)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_write(rsp_write), .rsp_err(rsp_err), .timeout(timeout)
    );

    fifo_apb_master #(.addr_width(8), .data_width(16), .timeout_cycles(0)) dut_z (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty_z), .fifo_dout(fifo_dout_z),
        .fifo_rd_en(fifo_rd_en_z), .psel(psel_z), .penable(penable_z), .pwrite(pwrite_z),
        .paddr(paddr_z), .pwdata(pwdata_z), .prdata(prdata_z), .pready(pready_z),
        .pslverr(pslverr_z), .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
        .rsp_data(rsp_data_z), .rsp_write(rsp_write_z), .rsp_err(rsp_err_z), .timeout(timeout_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty   = (wp == rp);
    assign fifo_dout    = mem[rp];
    assign prdata       = echo_mode ? {8'hC0, paddr} : prdata_val;
    assign fifo_empty_z = (push_z == pop_z);
    assign fifo_dout_z  = {1'b0, 8'h40, 16'h0000};

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (fifo_rd_en === 1'b1) begin
            pop_cyc[pops] = cyc;
            pops = pops + 1;
            rp <= rp + 4'd1;
        end
        if (fifo_rd_en_z === 1'b1) pop_z <= pop_z + 1;
    end

    task automatic push(input logic [24:0] w);
        mem[wp] = w;
        wp = wp + 4'd1;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        push({1'b1, 8'h55, 16'h0F0F});
        #1;
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
        total++; if ({psel, penable, rsp_valid, timeout, rsp_err, rsp_write} !== 6'b0) begin
            bad++; $display("FAIL rst_ctrl: psel/penable/rsp_valid/timeout/rsp_err/rsp_write=%b want 000000",
                            {psel, penable, rsp_valid, timeout, rsp_err, rsp_write}); end
        total++; if ({paddr, pwdata, rsp_data} !== 40'h0) begin
            bad++; $display("FAIL rst_data: paddr=%h pwdata=%h rsp_data=%h want 0", paddr, pwdata, rsp_data); end
        @(negedge clk);
        rst = 1'b0;
        pready = 1'b1;
        rsp_ready = 1'b1;
        #1;
        total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL rst_release_pop: got %b want 1", fifo_rd_en); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b0 || n != 3) begin
            bad++; $display("FAIL rst_drain: valid=%b write=%b err=%b after %0d cycles want 1 1 0 after 3",
                            rsp_valid, rsp_write, rsp_err, n); end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_write;
        int p0;
        pready = 1'b1;
        rsp_ready = 1'b0;
        p0 = pops;
        push({1'b1, 8'h3C, 16'hA5A5});
        #1;
        total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL wr_pop: got %b want 1", fifo_rd_en); end
        @(negedge clk);
        total++; if ({psel, penable, pwrite} !== 3'b101 || paddr !== 8'h3C || pwdata !== 16'hA5A5 || fifo_rd_en !== 1'b0) begin
            bad++; $display("FAIL wr_setup: sel/en/wr=%b paddr=%h pwdata=%h rd_en=%b want 101 3c a5a5 0",
                            {psel, penable, pwrite}, paddr, pwdata, fifo_rd_en); end
        @(negedge clk);
        total++; if ({psel, penable, pwrite} !== 3'b111 || paddr !== 8'h3C || pwdata !== 16'hA5A5) begin
            bad++; $display("FAIL wr_access: sel/en/wr=%b paddr=%h pwdata=%h want 111 3c a5a5",
                            {psel, penable, pwrite}, paddr, pwdata); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_data !== 16'h0 || rsp_err !== 1'b0 || {psel, penable} !== 2'b00) begin
            bad++; $display("FAIL wr_rsp: valid=%b write=%b data=%h err=%b sel/en=%b want 1 1 0000 0 00",
                            rsp_valid, rsp_write, rsp_data, rsp_err, {psel, penable}); end
        total++; if (pops != p0 + 1) begin bad++; $display("FAIL wr_pop_count: got %0d want %0d", pops - p0, 1); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_accept: rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_read_wait;
        pready = 1'b0;
        prdata_val = 16'h1234;
        push({1'b0, 8'h10, 16'hDEAD});
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++; if ({psel, penable, pwrite} !== 3'b110 || paddr !== 8'h10) begin
                bad++; $display("FAIL rd_access%0d: sel/en/wr=%b paddr=%h want 110 10", k, {psel, penable, pwrite}, paddr); end
            if (k == 4) pready = 1'b1;
        end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_err !== 1'b0 || rsp_write !== 1'b0 || timeout !== 1'b0 || penable !== 1'b0) begin
            bad++; $display("FAIL rd_rsp: valid=%b data=%h err=%b write=%b timeout=%b penable=%b want 1 1234 0 0 0 0",
                            rsp_valid, rsp_data, rsp_err, rsp_write, timeout, penable); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_slverr;
        pready = 1'b1;
        pslverr = 1'b1;
        prdata_val = 16'hFFFF;
        push({1'b0, 8'h20, 16'h0000});
        repeat (3) @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || timeout !== 1'b0) begin
            bad++; $display("FAIL slverr_rsp: valid=%b err=%b data=%h timeout=%b want 1 1 0000 0",
                            rsp_valid, rsp_err, rsp_data, timeout); end
        pslverr = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout;
        pready = 1'b0;
        push({1'b0, 8'h30, 16'h0000});
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++; if ({psel, penable} !== 2'b11 || timeout !== 1'b0 || rsp_valid !== 1'b0) begin
                bad++; $display("FAIL to_access%0d: sel/en=%b timeout=%b valid=%b want 11 0 0",
                                k, {psel, penable}, timeout, rsp_valid); end
        end
        @(negedge clk);
        total++; if (psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0 || timeout !== 1'b1) begin
            bad++; $display("FAIL to_abort: psel=%b valid=%b err=%b data=%h timeout=%b want 0 1 1 0000 1",
                            psel, rsp_valid, rsp_err, rsp_data, timeout); end
        @(negedge clk);
        total++; if (timeout !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            bad++; $display("FAIL to_pulse: timeout=%b valid=%b err=%b want 0 1 1", timeout, rsp_valid, rsp_err); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout_zero;
        int bad_cyc;
        pready_z = 1'b0;
        rsp_ready_z = 1'b0;
        push_z++;
        @(negedge clk);
        total++; if ({psel_z, penable_z, pwrite_z} !== 3'b100 || paddr_z !== 8'h40 || pwdata_z !== 16'h0) begin
            bad++; $display("FAIL z_setup: sel/en/wr=%b paddr=%h pwdata=%h want 100 40 0000",
                            {psel_z, penable_z, pwrite_z}, paddr_z, pwdata_z); end
        bad_cyc = 0;
        repeat (200) begin
            @(negedge clk);
            if (!(psel_z === 1'b1 && penable_z === 1'b1 && rsp_valid_z === 1'b0 && timeout_z === 1'b0)) bad_cyc++;
        end
        total++; if (bad_cyc != 0) begin bad++; $display("FAIL z_no_abort: %0d cycles left ACCESS, want 0", bad_cyc); end
        pready_z = 1'b1;
        prdata_z = 16'h5A5A;
        rsp_ready_z = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid_z !== 1'b1 || rsp_data_z !== 16'h5A5A || rsp_err_z !== 1'b0 || rsp_write_z !== 1'b0 || timeout_z !== 1'b0) begin
            bad++; $display("FAIL z_rsp: valid=%b data=%h err=%b write=%b timeout=%b want 1 5a5a 0 0 0",
                            rsp_valid_z, rsp_data_z, rsp_err_z, rsp_write_z, timeout_z); end
        @(negedge clk);
        rsp_ready_z = 1'b0;
        pready_z = 1'b0;
    endtask

    task automatic test_back_to_back;
        int p0, n, got;
        logic ok;
        logic [15:0] d1, d2;
        logic w1, w2, e1, e2;
        d1 = 16'h0; d2 = 16'h0; w1 = 1'b1; w2 = 1'b1; e1 = 1'b1; e2 = 1'b1;
        pready = 1'b1;
        rsp_ready = 1'b0;
        echo_mode = 1'b1;
        p0 = pops;
        push({1'b1, 8'h60, 16'h1111});
        push({1'b0, 8'h61, 16'h0000});
        push({1'b0, 8'h62, 16'h0000});
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL b2b_first: valid=%b write=%b data=%h err=%b want 1 1 0000 0",
                            rsp_valid, rsp_write, rsp_data, rsp_err); end
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_write === 1'b1 && rsp_data === 16'h0 && rsp_err === 1'b0 &&
                  psel === 1'b0 && pops == p0 + 1)) ok = 1'b0;
        end
        total++; if (!ok) begin bad++; $display("FAIL b2b_hold: response changed or extra pop, pops=%0d want 1", pops - p0); end
        rsp_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 2 && n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) begin
                if (got == 0) begin d1 = rsp_data; w1 = rsp_write; e1 = rsp_err; end
                else begin d2 = rsp_data; w2 = rsp_write; e2 = rsp_err; end
                got++;
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        echo_mode = 1'b0;
        total++; if (got != 2 || d1 !== 16'hC061 || w1 !== 1'b0 || e1 !== 1'b0 || d2 !== 16'hC062 || w2 !== 1'b0 || e2 !== 1'b0) begin
            bad++; $display("FAIL b2b_order: got=%0d d1=%h w1=%b e1=%b d2=%h w2=%b e2=%b want 2 c061 0 0 c062 0 0",
                            got, d1, w1, e1, d2, w2, e2); end
        total++; if (pops != p0 + 3 || pop_cyc[p0+1] - pop_cyc[p0] < 4 || pop_cyc[p0+2] - pop_cyc[p0+1] < 4) begin
            bad++; $display("FAIL b2b_spacing: pops=%0d gaps=%0d,%0d want 3 pops with gaps >=4",
                            pops - p0, pop_cyc[p0+1] - pop_cyc[p0], pop_cyc[p0+2] - pop_cyc[p0+1]); end
    endtask

    task automatic test_reset_mid;
        int p0, n;
        logic [7:0] seen_addr;
        pready = 1'b0;
        rsp_ready = 1'b1;
        seen_addr = 8'h00;
        p0 = pops;
        push({1'b0, 8'h70, 16'h0000});
        push({1'b1, 8'h71, 16'h7777});
        repeat (2) @(negedge clk);
        total++; if ({psel, penable} !== 2'b11 || paddr !== 8'h70) begin
            bad++; $display("FAIL rm_access: sel/en=%b paddr=%h want 11 70", {psel, penable}, paddr); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({psel, penable, rsp_valid} !== 3'b000 || fifo_rd_en !== 1'b0 || pops != p0 + 1) begin
            bad++; $display("FAIL rm_reset: sel/en/valid=%b rd_en=%b pops=%0d want 000 0 1",
                            {psel, penable, rsp_valid}, fifo_rd_en, pops - p0); end
        rst = 1'b0;
        pready = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
            if (penable === 1'b1) seen_addr = paddr;
        end
        total++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 16'h0 ||
                     seen_addr !== 8'h71 || pops != p0 + 2) begin
            bad++; $display("FAIL rm_next: valid=%b write=%b err=%b data=%h addr=%h pops=%0d want 1 1 0 0000 71 2",
                            rsp_valid, rsp_write, rsp_err, rsp_data, seen_addr, pops - p0); end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cyc = 0; pops = 0; push_z = 0; pop_z = 0;
        wp = 4'd0; rp = 4'd0;
        rst = 1'b1;
        pready = 1'b0; pslverr = 1'b0; prdata_val = 16'h0; rsp_ready = 1'b0; echo_mode = 1'b0;
        pready_z = 1'b0; pslverr_z = 1'b0; prdata_z = 16'h0; rsp_ready_z = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_timeout_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
